// File: rtl/mux_4to1_8bit_pkg.sv
// Shared constants and select-code type for the 2:1 / 4:1 registered mux block.
package mux_4to1_8bit_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned SEL4_W        = 2;

   typedef enum logic [SEL4_W-1:0] {
      SEL_IN0 = 2'b00,
      SEL_IN1 = 2'b01,
      SEL_IN2 = 2'b10,
      SEL_IN3 = 2'b11
   } sel4_t;

endpackage : mux_4to1_8bit_pkg

// File: rtl/mux_2to1_8bit.sv
// Combinational 2:1 selector; an unknown select yields all-zeros so the
// registered outputs downstream stay deterministic in simulation.
module mux_2to1_8bit
   import mux_4to1_8bit_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sel,
   output logic [WIDTH-1:0] o_y_c
);

   always_comb begin
      o_y_c = '0;
      case (i_sel)
         1'b0:    o_y_c = i_a;
         1'b1:    o_y_c = i_b;
         default: o_y_c = '0;
      endcase
   end

endmodule : mux_2to1_8bit

// File: rtl/mux_4to1_8bit.sv
// Independent registered 2:1 and 4:1 selectors sharing in0/in1; the 4:1 path
// is a three-node tree of 2:1 muxes (sel4[0] at the leaves, sel4[1] at the root).
module mux_4to1_8bit
   import mux_4to1_8bit_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [WIDTH-1:0]  in0,
   input  logic [WIDTH-1:0]  in1,
   input  logic [WIDTH-1:0]  in2,
   input  logic [WIDTH-1:0]  in3,
   input  logic              sel2,
   input  logic [SEL4_W-1:0] sel4,
   output logic [WIDTH-1:0]  out2,
   output logic [WIDTH-1:0]  out4
);

   logic [WIDTH-1:0] w_mux2_c;
   logic [WIDTH-1:0] w_leaf_lo_c;
   logic [WIDTH-1:0] w_leaf_hi_c;
   logic [WIDTH-1:0] w_mux4_c;
   logic [WIDTH-1:0] r_out2;
   logic [WIDTH-1:0] r_out4;

   mux_2to1_8bit #(.WIDTH(WIDTH)) u_mux2 (
      .i_a   (in0),
      .i_b   (in1),
      .i_sel (sel2),
      .o_y_c (w_mux2_c)
   );

   mux_2to1_8bit #(.WIDTH(WIDTH)) u_leaf_lo (
      .i_a   (in0),
      .i_b   (in1),
      .i_sel (sel4[0]),
      .o_y_c (w_leaf_lo_c)
   );

   mux_2to1_8bit #(.WIDTH(WIDTH)) u_leaf_hi (
      .i_a   (in2),
      .i_b   (in3),
      .i_sel (sel4[0]),
      .o_y_c (w_leaf_hi_c)
   );

   mux_2to1_8bit #(.WIDTH(WIDTH)) u_root (
      .i_a   (w_leaf_lo_c),
      .i_b   (w_leaf_hi_c),
      .i_sel (sel4[1]),
      .o_y_c (w_mux4_c)
   );

   // Both output registers; reset clears them immediately and overrides en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out2 <= '0;
         r_out4 <= '0;
      end else if (en) begin
         r_out2 <= w_mux2_c;
         r_out4 <= w_mux4_c;
      end
   end

   assign out2 = r_out2;
   assign out4 = r_out4;

endmodule : mux_4to1_8bit

// File: tb/tb_mux_4to1_8bit.sv
// Bench for mux_4to1_8bit: table vectors, random vectors against a small model,
// and hand-written reset sequences, all checked through an expected-value queue.
module tb_mux_4to1_8bit;
   import mux_4to1_8bit_pkg::*;

   localparam int unsigned W = DEFAULT_WIDTH;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [W-1:0]     in0, in1, in2, in3;
   logic             sel2;
   logic [1:0]       sel4;
   logic [W-1:0]     out2, out4;

   typedef struct packed {
      logic         en;
      logic [W-1:0] in0;
      logic [W-1:0] in1;
      logic [W-1:0] in2;
      logic [W-1:0] in3;
      logic         sel2;
      sel4_t        sel4;
      logic [W-1:0] exp2;
      logic [W-1:0] exp4;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] e2;
      logic [W-1:0] e4;
   } exp_t;

   exp_t         sb_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] last2 = '0;
   logic [W-1:0] last4 = '0;
   vec_t         vecs[12];

   mux_4to1_8bit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .in0   (in0),
      .in1   (in1),
      .in2   (in2),
      .in3   (in3),
      .sel2  (sel2),
      .sel4  (sel4),
      .out2  (out2),
      .out4  (out4)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [W-1:0] model4(input logic [1:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c,
                                           input logic [W-1:0] d);
      logic [W-1:0] arr[4];
      arr = '{a, b, c, d};
      return arr[s];
   endfunction

   // Build a vector whose expectation comes from the model (holding when en=0).
   function automatic vec_t mk(input logic e, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] d,
                               input logic s2, input logic [1:0] s4,
                               input logic [W-1:0] p2, input logic [W-1:0] p4);
      vec_t v;
      v.en = e; v.in0 = a; v.in1 = b; v.in2 = c; v.in3 = d;
      v.sel2 = s2; v.sel4 = sel4_t'(s4);
      v.exp2 = e ? (s2 ? b : a) : p2;
      v.exp4 = e ? model4(s4, a, b, c, d) : p4;
      return v;
   endfunction

   task automatic push(input logic [W-1:0] e2, input logic [W-1:0] e4);
      exp_t x;
      x.e2 = e2; x.e4 = e4;
      sb_q.push_back(x);
      last2 = e2; last4 = e4;
   endtask

   task automatic check(input string tag);
      exp_t x;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: got empty scoreboard required an expected entry", tag);
         return;
      end
      x = sb_q.pop_front();
      if (out2 !== x.e2) begin
         n_err++;
         $display("FAIL %s out2: got %h required %h", tag, out2, x.e2);
      end
      n_vec++;
      if (out4 !== x.e4) begin
         n_err++;
         $display("FAIL %s out4: got %h required %h", tag, out4, x.e4);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      en = v.en; in0 = v.in0; in1 = v.in1; in2 = v.in2; in3 = v.in3;
      sel2 = v.sel2; sel4 = v.sel4;
      push(v.exp2, v.exp4);
      @(posedge clk);
      #1;
      check(tag);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b0, SEL_IN0, 8'hAA, 8'hAA};
      vecs[1]  = '{1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, SEL_IN1, 8'h55, 8'h55};
      vecs[2]  = '{1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, SEL_IN2, 8'h55, 8'hFF};
      vecs[3]  = '{1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, SEL_IN3, 8'h55, 8'h00};
      vecs[4]  = '{1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b0, SEL_IN0, 8'hAA, 8'hAA};
      vecs[5]  = '{1'b0, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, SEL_IN2, 8'hAA, 8'hAA};
      vecs[6]  = '{1'b0, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, SEL_IN3, 8'hAA, 8'hAA};
      vecs[7]  = '{1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b0, SEL_IN2, 8'hAA, 8'hFF};
      vecs[8]  = '{1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, SEL_IN1, 8'h55, 8'h55};
      vecs[9]  = '{1'b1, 8'hAA, 8'h55, 8'h0F, 8'h00, 1'b1, SEL_IN2, 8'h55, 8'h0F};
      vecs[10] = '{1'b1, 8'h3C, 8'hC3, 8'h81, 8'h7E, 1'b0, SEL_IN3, 8'h3C, 8'h7E};
      vecs[11] = '{1'b1, 8'h3C, 8'hC3, 8'h81, 8'h7E, 1'b1, SEL_IN0, 8'hC3, 8'h3C};

      // Reset state, and reset overriding an enabled clock edge.
      rst_n = 1'b0; en = 1'b0; sel2 = 1'b0; sel4 = 2'b00;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      #2;
      push('0, '0);
      check("reset_state");
      en = 1'b1; in0 = 8'hAA; in1 = 8'h55; sel2 = 1'b1; sel4 = 2'b01;
      @(posedge clk); #1;
      push('0, '0);
      check("reset_over_en");
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      push('0, '0);
      check("release_en0_hold");

      for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("table%0d", i));

      for (int i = 0; i < 40; i++) begin
         apply(mk(1'(($urandom_range(0, 3) != 0)), W'($urandom), W'($urandom), W'($urandom),
                  W'($urandom), 1'($urandom), 2'($urandom), last2, last4),
               $sformatf("rand%0d", i));
      end

      // Asynchronous reset between clock edges after out4 holds FF.
      apply(mk(1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b0, 2'b10, last2, last4), "pre_rst_ff");
      #3;
      rst_n = 1'b0;
      #1;
      push('0, '0);
      check("async_rst_mid_cycle");
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      push('0, '0);
      check("rst_release_hold");
      apply(mk(1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, 2'b10, last2, last4), "first_en_edge");

      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mux_4to1_8bit
